// File: rtl/bmp280_pkg.sv
// Shared definitions for the BMP280 word dump path: ASCII constants, the
// per-word character count, FSM state types and hex/character helpers.
package bmp280_pkg;

  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;
  localparam int unsigned DUMP_CHARS = 6;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic {
    DUMP_IDLE,
    DUMP_SEND
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + 8'(nib);
    else             return 8'h37 + 8'(nib);
  endfunction

  // Character idx of the dump line: four hex digits MSB first, then CR, LF
  function automatic logic [7:0] dump_char(input logic [15:0]      word,
                                           input logic [IDX_W-1:0] idx);
    logic [7:0] ch;
    case (idx)
      3'd0:    ch = nibble_to_ascii(word[15:12]);
      3'd1:    ch = nibble_to_ascii(word[11:8]);
      3'd2:    ch = nibble_to_ascii(word[7:4]);
      3'd3:    ch = nibble_to_ascii(word[3:0]);
      3'd4:    ch = ASCII_CR;
      default: ch = ASCII_LF;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a fixed baud divisor.
// Ports: clk12MHz/rst (sync, active-high); start + data load a byte (honoured
// when idle or in the last stop-bit cycle, giving gapless back-to-back
// characters); tx is the registered line output; done pulses in the final
// stop-bit cycle.
module uart_tx_byte
  import bmp280_pkg::*;
#(
  parameter int unsigned DIVISOR = 104
) (
  input  logic       clk12MHz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned BAUD_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_wrap;

  // Next-state: the line value for the next bit is registered at the edge
  // that starts that bit, so tx never has a combinational path.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done      = 1'b0;
    baud_wrap = (baud_q == BAUD_LAST);

    if (state_q != TX_IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = TX_START;
          tx_d    = 1'b0;
          shift_d = data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      TX_START: begin
        if (baud_wrap) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (baud_wrap) begin
          done = 1'b1;
          if (start) begin
            state_d = TX_START;
            tx_d    = 1'b0;
            shift_d = data;
            baud_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/spi_word_uart_dump.sv
// Dumps each accepted 16-bit word as "HHHH\r\n" on an 8N1 UART line.
// Ports: clk12MHz/rst (sync, active-high); word_in/word_valid/word_ready
// valid-ready input (words offered while busy wait, they are not queued);
// tx UART line (idles high); busy = ~word_ready.
module spi_word_uart_dump
  import bmp280_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 12000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned DIVISOR = CLK_HZ / BAUD
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("spi_word_uart_dump: DIVISOR must be at least 2");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_CHARS - 1);

  dump_state_e      state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             ser_start_c;
  logic [7:0]       ser_char_c;
  logic             ser_done;

  // Top FSM; the NEXT decision is folded into the serializer-done cycle so
  // the following character starts with no gap. The first character comes
  // straight from word_in because the holding register loads on the same edge.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    ser_start_c = 1'b0;
    ser_char_c  = dump_char(word_q, idx_q);

    case (state_q)
      DUMP_IDLE: begin
        if (word_valid) begin
          state_d     = DUMP_SEND;
          word_d      = word_in;
          idx_d       = '0;
          ser_start_c = 1'b1;
          ser_char_c  = dump_char(word_in, '0);
        end
      end
      DUMP_SEND: begin
        if (ser_done) begin
          if (idx_q < LAST_IDX) begin
            idx_d       = idx_q + IDX_W'(1);
            ser_start_c = 1'b1;
            ser_char_c  = dump_char(word_q, idx_q + IDX_W'(1));
          end else begin
            state_d = DUMP_IDLE;
          end
        end
      end
      default: state_d = DUMP_IDLE;
    endcase

    ready_d = (state_d == DUMP_IDLE);
    busy_d  = ~ready_d;
  end

  // State register
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state_q <= DUMP_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  uart_tx_byte #(
    .DIVISOR (DIVISOR)
  ) u_tx (
    .clk12MHz (clk12MHz),
    .rst      (rst),
    .start    (ser_start_c),
    .data     (ser_char_c),
    .tx       (tx),
    .done     (ser_done)
  );

  assign word_ready = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_word_uart_dump.sv
// Bench for spi_word_uart_dump: a DIVISOR=4 instance for most scenarios and a
// default-divisor instance for the full-rate word. Expected line waveforms are
// built from the text of each dump line ("HHHH\r\n") and the 8N1 framing rule.
module tb_spi_word_uart_dump;

  logic        clk12MHz = 1'b0;
  logic        rst;
  logic [15:0] word_in, word_in_b;
  logic        word_valid, word_valid_b;
  logic        word_ready, tx, busy;
  logic        word_ready_b, tx_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk12MHz = ~clk12MHz;

  spi_word_uart_dump #(.DIVISOR(4)) dut (
    .clk12MHz   (clk12MHz),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .tx         (tx),
    .busy       (busy)
  );

  spi_word_uart_dump dut_b (
    .clk12MHz   (clk12MHz),
    .rst        (rst),
    .word_in    (word_in_b),
    .word_valid (word_valid_b),
    .word_ready (word_ready_b),
    .tx         (tx_b),
    .busy       (busy_b)
  );

  task automatic step();
    @(posedge clk12MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Character c of the dump line for word w
  function automatic logic [7:0] model_char(input logic [15:0] w, input int c);
    string      hex = "0123456789ABCDEF";
    logic [15:0] t;
    if (c < 4) begin
      t = w >> (12 - 4 * c);
      return 8'(hex.getc(int'(t[3:0])));
    end
    return (c == 4) ? 8'h0D : 8'h0A;
  endfunction

  // Line level i cycles after the accepting edge
  function automatic logic model_bit(input logic [15:0] w, input int d, input int i);
    int p = i / d;
    int b = p % 10;
    logic [7:0] ch = model_char(w, p / 10);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  // Called just after the accepting edge; follows the whole word cycle by cycle
  task automatic capture(input logic [15:0] w, input int d, input bit big, input bit hold,
                         input int chg_at, input logic [15:0] chg_w, input string tag);
    int         bad = 0;
    int         busy_n = 0;
    int         rdy_n = 0;
    int         p;
    logic [7:0] dec [6];
    logic       t, b, r;
    for (int c = 0; c < 6; c++) dec[c] = '0;
    if (!hold) begin
      if (big) begin word_valid_b = 1'b0; word_in_b = 16'($urandom); end
      else     begin word_valid   = 1'b0; word_in   = 16'($urandom); end
    end
    for (int i = 0; i < 60 * d; i++) begin
      if (i == chg_at) word_in = chg_w;
      t = big ? tx_b : tx;
      b = big ? busy_b : busy;
      r = big ? word_ready_b : word_ready;
      if (t !== model_bit(w, d, i)) bad++;
      if (b === 1'b1) busy_n++;
      if (r === 1'b0) rdy_n++;
      p = i / d;
      if ((i % d) == d / 2 && (p % 10) >= 1 && (p % 10) <= 8) dec[p/10][(p%10)-1] = t;
      step();
    end
    check({tag, " wave_bad_cycles"}, 32'(bad), 32'd0);
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(60 * d));
    check({tag, " not_ready_cycles"}, 32'(rdy_n), 32'(60 * d));
    for (int c = 0; c < 6; c++)
      check($sformatf("%s char%0d", tag, c), 32'(dec[c]), 32'(model_char(w, c)));
    check({tag, " tx_after"}, 32'(big ? tx_b : tx), 32'd1);
    check({tag, " ready_after"}, 32'(big ? word_ready_b : word_ready), 32'd1);
    check({tag, " busy_after"}, 32'(big ? busy_b : busy), 32'd0);
  endtask

  task automatic send(input logic [15:0] w, input string tag);
    word_in    = w;
    word_valid = 1'b1;
    check({tag, " ready_before"}, 32'(word_ready), 32'd1);
    step();
    capture(w, 4, 1'b0, 1'b0, -1, 16'h0, tag);
  endtask

  initial begin
    int low_n, nrdy_n, gap;
    logic [15:0] w;

    // Reset, with word_valid high to show reset wins
    rst = 1'b1; word_in = 16'h0060; word_valid = 1'b1;
    word_in_b = 16'h0; word_valid_b = 1'b1;
    step(); step();
    check("rst tx", 32'(tx), 32'd1);
    check("rst ready", 32'(word_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tx_b", 32'(tx_b), 32'd1);
    check("rst ready_b", 32'(word_ready_b), 32'd1);
    word_valid = 1'b0; word_valid_b = 1'b0;
    rst = 1'b0;
    step();
    check("idle tx", 32'(tx), 32'd1);

    // Pulsed single words
    send(16'h0060, "w0060");
    step();
    send(16'hABCF, "wABCF");

    // Random words with random idle gaps
    for (int k = 0; k < 3; k++) begin
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) step();
      w = 16'($urandom);
      send(w, $sformatf("rand%0d", k));
    end

    // valid held through a dump; new word presented mid-dump
    step();
    word_in = 16'h1234; word_valid = 1'b1;
    step();
    capture(16'h1234, 4, 1'b0, 1'b1, 100, 16'hFFFF, "hold1234");
    step();
    capture(16'hFFFF, 4, 1'b0, 1'b0, -1, 16'h0, "holdFFFF");
    low_n = 0; nrdy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1) low_n++;
      if (word_ready !== 1'b1) nrdy_n++;
      step();
    end
    check("no_dup tx_low", 32'(low_n), 32'd0);
    check("no_dup not_ready", 32'(nrdy_n), 32'd0);

    // Reset 50 cycles into a dump
    word_in = 16'h5A5A; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check("midrst tx_before", 32'(tx), 32'(model_bit(16'h5A5A, 4, 50)));
    check("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("midrst tx", 32'(tx), 32'd1);
    check("midrst ready", 32'(word_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    check("midrst idle_tx", 32'(tx), 32'd1);
    send(16'h0000, "w0000");

    // Default divisor
    word_in_b = 16'h8000; word_valid_b = 1'b1;
    check("big ready_before", 32'(word_ready_b), 32'd1);
    step();
    capture(16'h8000, 104, 1'b1, 1'b0, -1, 16'h0, "big8000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
